// File: rtl/uart_msg_sequencer.sv
// Drives the byte-level UART TX with an "LED:bbbb" status line on every accepted trigger.
// Counts triggers dropped while a line is in flight and aborts a line whose byte stalls too long.
module uart_msg_sequencer #(
  parameter int unsigned USE_CRLF       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [3:0] led_state,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       seq_busy,
  output logic       line_done,
  output logic       timeout_err,
  output logic [7:0] overrun_cnt
);

  localparam int unsigned CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST   = (USE_CRLF != 0) ? 4'd9 : 4'd8;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    idx, idx_nxt;
  logic [3:0]    snap, snap_nxt;
  logic [CW-1:0] tcnt, tcnt_nxt;
  logic          terr_nxt;
  logic [7:0]    ovr_nxt;
  logic [7:0]    byte_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      snap        <= '0;
      tcnt        <= '0;
      timeout_err <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      snap        <= snap_nxt;
      tcnt        <= tcnt_nxt;
      timeout_err <= terr_nxt;
      overrun_cnt <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    snap_nxt  = snap;
    tcnt_nxt  = tcnt;
    terr_nxt  = timeout_err;
    tx_valid  = 1'b0;
    line_done = 1'b0;
    case (state)
      IDLE: begin
        if (tx_start) begin
          snap_nxt  = led_state;
          idx_nxt   = '0;
          tcnt_nxt  = '0;
          terr_nxt  = 1'b0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        // A transfer on the limit cycle wins over the timeout.
        if (tx_ready) begin
          tcnt_nxt = '0;
          if (idx == LAST) state_nxt = DONE;
          else             idx_nxt   = idx + 4'd1;
        end else if (tcnt == LIMIT) begin
          terr_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      DONE: begin
        line_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ovr_nxt = overrun_cnt;
    if (tx_start && (state != IDLE) && (overrun_cnt != '1)) ovr_nxt = overrun_cnt + 8'd1;
  end

  always_comb begin
    byte_sel = '0;
    case (idx)
      4'd0: byte_sel = 8'h4C;
      4'd1: byte_sel = 8'h45;
      4'd2: byte_sel = 8'h44;
      4'd3: byte_sel = 8'h3A;
      4'd4: byte_sel = {7'b0011000, snap[3]};
      4'd5: byte_sel = {7'b0011000, snap[2]};
      4'd6: byte_sel = {7'b0011000, snap[1]};
      4'd7: byte_sel = {7'b0011000, snap[0]};
      4'd8: byte_sel = (USE_CRLF != 0) ? 8'h0D : 8'h0A;
      4'd9: byte_sel = 8'h0A;
      default: byte_sel = '0;
    endcase
  end

  assign tx_data  = tx_valid ? byte_sel : '0;
  assign seq_busy = (state != IDLE);

endmodule
